sd_serializer: RTL and testbench
================================

Name: sd_serializer

Overview:
- Splits one wide parallel word into NUM_SEG narrow segments and emits them LSB-segment first over srdy/drdy.
- Asserts an end flag (p_ef) on the final segment.
- This is the transmit-side counterpart of the sd deserializer: its p_* output connects directly to a deserializer's c_* input, and the deserializer rebuilds the original PARA_WIDTH word.
- Has a single-word holding register and supports back-to-back words with no bubble.

Parameters:
- PARA_WIDTH, 63: width of the parallel input word.
- SER_WIDTH, 8: width of each serial segment.
- Derived NUM_SEG = ceil(PARA_WIDTH/SER_WIDTH).
- Derived LAST_SEG_WIDTH = PARA_WIDTH - (NUM_SEG-1)*SER_WIDTH.
- Derived SEG_SZ = max(1, $clog2(NUM_SEG)).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- c_data  in  PARA_WIDTH  parallel word to serialize.
- c_srdy  in  1  c_data valid.
- c_drdy  out  1  block can accept c_data this cycle.
- p_data  out  SER_WIDTH  current segment.
- p_ef  out  1  end flag; high on the last segment of a word.
- p_srdy  out  1  p_data/p_ef valid.
- p_drdy  in  1  downstream accepts the segment.

Behaviour:
- State:
  - busy flag (IDLE=0, BUSY=1).
  - hold register, NUM_SEG*SER_WIDTH bits.
  - seg_num counter, SEG_SZ bits.
- Reset (reset=0, asynchronous): busy=0 and seg_num=0. Outputs while in reset: p_srdy=0, p_ef=0, c_drdy=1. The hold register is not reset.
- Transfers: an input transfer occurs when c_srdy && c_drdy. An output transfer occurs when p_srdy && p_drdy.
- Output signals:
  - p_srdy = busy.
  - p_data = hold[seg_num*SER_WIDTH +: SER_WIDTH].
  - p_ef = busy && (seg_num == NUM_SEG-1).
  - All three are driven purely from registers, with no combinational path from the p_drdy or c_* inputs.
- c_drdy = ~busy || (p_drdy && p_ef). This is the only combinational input-to-output path.
- Latency: a word accepted on edge N presents segment 0 in the cycle after edge N. A word takes at least NUM_SEG cycles to drain.
- Load: on an input transfer:
  - hold <= c_data, zero-extended to NUM_SEG*SER_WIDTH.
  - seg_num <= 0.
  - busy <= 1.
  - In the last segment, bits [SER_WIDTH-1:LAST_SEG_WIDTH] are driven 0.
- Advance: on an output transfer with p_ef=0, seg_num <= seg_num+1. The hold register and busy are unchanged.
- Final segment: on an output transfer with p_ef=1:
  - If an input transfer occurs in the same cycle, the Load action applies (back-to-back, no idle cycle).
  - Otherwise busy <= 0 and seg_num <= 0.
- Backpressure: while p_srdy=1 and p_drdy=0, p_data, p_ef and seg_num hold stable, and c_drdy=0 unless idle.
- NUM_SEG=1 (PARA_WIDTH <= SER_WIDTH): every segment has p_ef=1, the block acts as a one-entry pipeline register, and throughput is 1 word per cycle.
- Counter wrap: seg_num never exceeds NUM_SEG-1. When NUM_SEG is not a power of 2, the unused encodings are unreachable.
- Reset asserted mid-word: the partially sent word is discarded. After reset deasserts, p_srdy=0 and the next accepted word starts at segment 0.
- Protocol: c_data is sampled only on an input transfer. Upstream may change c_data freely while c_drdy=0.

Test Plan:
- Single word, p_drdy held at 1, with c_data=63'h7EDC_BA98_7654_3210:
  - p_data sequence is 10,32,54,76,98,BA,DC,7E on 8 consecutive cycles, starting the cycle after acceptance.
  - p_ef=1 only on 7E; bit 7 of the last segment is 0.
  - After the last segment, p_srdy=0.
- Back-to-back: c_srdy held at 1 with two words A and B.
  - B is accepted in the same cycle as A's p_ef transfer (c_drdy=1 only in that cycle).
  - B's segment 0 follows A's last segment with no gap.
  - 16 segments are delivered in 16 cycles.
- Backpressure: drop p_drdy for 3 cycles at segment 3 and again at the last segment.
  - p_data and p_ef stay stable during each stall.
  - c_drdy=0 throughout the stalls.
  - No segment is lost or duplicated.
- Loopback: connect the output to an sd_deserializer(63,8) and send 100 random words with random p_drdy/c_srdy gaps. The received words must match the sent words exactly, in order.
- Reset mid-word: assert reset (low) asynchronously after segment 2.
  - p_srdy falls immediately.
  - After release, a new word C is sent from segment 0 and the old word does not reappear.
- PARA_WIDTH=8, SER_WIDTH=8: every output has p_ef=1, and continuous c_srdy/p_drdy yields 1 word per cycle.

Source files
------------

// File: rtl/sd_serializer_if.sv
// Parallel-in / serial-out handshake bundle for sd_serializer.
// master is the serializer's view; slave is the upstream/downstream environment's view.
interface sd_serializer_if #(
    parameter int PARA_WIDTH = 63,
    parameter int SER_WIDTH  = 8
);
    logic [PARA_WIDTH-1:0] c_data;
    logic                  c_srdy;
    logic                  c_drdy;
    logic [SER_WIDTH-1:0]  p_data;
    logic                  p_ef;
    logic                  p_srdy;
    logic                  p_drdy;

    modport master (
        input  c_data, c_srdy, p_drdy,
        output c_drdy, p_data, p_ef, p_srdy
    );

    modport slave (
        output c_data, c_srdy, p_drdy,
        input  c_drdy, p_data, p_ef, p_srdy
    );
endinterface

// File: rtl/sd_serializer.sv
// Splits a PARA_WIDTH word into ceil(PARA_WIDTH/SER_WIDTH) segments, LSB segment first,
// flagging the last one with p_ef; a new word may load on the final segment's transfer.
module sd_serializer #(
    parameter int PARA_WIDTH = 63,
    parameter int SER_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    sd_serializer_if.master  bus
);
    localparam int NUM_SEG = (PARA_WIDTH + SER_WIDTH - 1) / SER_WIDTH;
    localparam int HOLD_W  = NUM_SEG * SER_WIDTH;
    localparam int SEG_SZ  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam logic [SEG_SZ-1:0] LAST_SEG = SEG_SZ'(NUM_SEG - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                             state, state_next;
    logic [SEG_SZ-1:0]                  seg_num, seg_next;
    logic [NUM_SEG-1:0][SER_WIDTH-1:0]  hold;
    logic                               load;
    logic                               advance;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            seg_num <= '0;
        end else begin
            state   <= state_next;
            seg_num <= seg_next;
        end
    end

    // Holding register is data-only; busy gates every use of it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load)
            hold <= HOLD_W'(bus.c_data);
    end

    always_comb begin
        bus.p_srdy  = (state == BUSY);
        bus.p_ef    = (state == BUSY) && (seg_num == LAST_SEG);
        bus.p_data  = hold[seg_num];
        bus.c_drdy  = (state == IDLE) || (bus.p_drdy && bus.p_ef);
        load        = bus.c_srdy && bus.c_drdy;
        advance     = bus.p_srdy && bus.p_drdy;
        state_next  = state;
        seg_next    = seg_num;
        if (load) begin
            state_next = BUSY;
            seg_next   = '0;
        end else if (advance) begin
            if (bus.p_ef) begin
                state_next = IDLE;
                seg_next   = '0;
            end else begin
                seg_next   = seg_num + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sd_serializer.sv
// Directed bench for sd_serializer (63/8 and 8/8 instances) with a reassembling
// scoreboard for the random-gap stream.
module tb_sd_serializer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_serializer_if #(.PARA_WIDTH(63), .SER_WIDTH(8)) bus ();
    sd_serializer_if #(.PARA_WIDTH(8),  .SER_WIDTH(8)) bus8 ();

    sd_serializer #(.PARA_WIDTH(63), .SER_WIDTH(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
    sd_serializer #(.PARA_WIDTH(8),  .SER_WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp1 [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'h7E};
    logic [62:0] word_a, word_b, word_c, word_d, word_w;
    logic [62:0] sent [$];
    logic [62:0] front;
    logic [63:0] acc;
    logic [7:0]  seq8 [6] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h3C, 8'h81};
    int          tx, rx, cnt, cyc;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %016h expected %016h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg(input logic [62:0] w, input int k);
        logic [63:0] t;
        t = {1'b0, w};
        return t[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present w with c_srdy=1, confirm acceptance at the next edge, then drop c_srdy.
    task automatic accept(input logic [62:0] w);
        bus.c_data = w;
        bus.c_srdy = 1'b1;
        @(negedge clk);
        chk_bit("accept_c_drdy", bus.c_drdy, 1'b1);
        tick();
        bus.c_srdy = 1'b0;
        bus.c_data = '1;
    endtask

    task automatic expect_seg(input string tag, input logic [62:0] w, input int k);
        @(negedge clk);
        chk_bit({tag, "_p_srdy"}, bus.p_srdy, 1'b1);
        chk_byte({tag, "_p_data"}, bus.p_data, seg(w, k));
        chk_bit({tag, "_p_ef"}, bus.p_ef, k == 7);
    endtask

    initial begin
        reset       = 1'b0;
        bus.c_data  = '0;
        bus.c_srdy  = 1'b0;
        bus.p_drdy  = 1'b0;
        bus8.c_data = '0;
        bus8.c_srdy = 1'b0;
        bus8.p_drdy = 1'b0;
        word_a = 63'h0123_4567_89AB_CDEF;
        word_b = 63'h5A5A_0F0F_F0F0_A5A5;
        word_c = 63'h1122_3344_5566_7788;
        word_d = 63'h7FFF_EEEE_DDDD_CCCC;
        word_w = 63'h3C3C_2B2B_1A1A_0909;

        @(negedge clk);
        chk_bit("rst_p_srdy", bus.p_srdy, 1'b0);
        chk_bit("rst_p_ef", bus.p_ef, 1'b0);
        chk_bit("rst_c_drdy", bus.c_drdy, 1'b1);
        chk_bit("rst8_p_srdy", bus8.p_srdy, 1'b0);
        tick();
        tick();
        reset = 1'b1;

        // Single word, downstream always ready.
        bus.p_drdy = 1'b1;
        accept(63'h7EDC_BA98_7654_3210);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_bit("single_p_srdy", bus.p_srdy, 1'b1);
            chk_byte("single_p_data", bus.p_data, exp1[k]);
            chk_bit("single_p_ef", bus.p_ef, k == 7);
            tick();
        end
        @(negedge clk);
        chk_bit("single_done_p_srdy", bus.p_srdy, 1'b0);
        tick();

        // Back-to-back: B is taken on A's final-segment transfer.
        bus.c_data = {1'b0, word_a};
        bus.c_srdy = 1'b1;
        @(negedge clk);
        chk_bit("b2b_accept_a", bus.c_drdy, 1'b1);
        tick();
        bus.c_data = word_b;
        for (int k = 0; k < 8; k++) begin
            expect_seg("b2b_a", word_a, k);
            chk_bit("b2b_a_c_drdy", bus.c_drdy, k == 7);
            tick();
        end
        bus.c_srdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_seg("b2b_b", word_b, k);
            tick();
        end
        @(negedge clk);
        chk_bit("b2b_done_p_srdy", bus.p_srdy, 1'b0);
        tick();

        // Backpressure stalls at segment 3 and at the last segment.
        accept(word_w);
        for (int k = 0; k < 8; k++) begin
            if (k == 3 || k == 7) begin
                bus.p_drdy = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    expect_seg("stall", word_w, k);
                    chk_bit("stall_c_drdy", bus.c_drdy, 1'b0);
                    tick();
                end
                bus.p_drdy = 1'b1;
            end
            expect_seg("bp", word_w, k);
            tick();
        end
        @(negedge clk);
        chk_bit("bp_done_p_srdy", bus.p_srdy, 1'b0);
        tick();

        // Reset mid-word after three segments have gone out.
        accept(word_d);
        for (int k = 0; k < 3; k++) begin
            expect_seg("pre_rst", word_d, k);
            tick();
        end
        #2 reset = 1'b0;
        #1;
        chk_bit("midrst_p_srdy", bus.p_srdy, 1'b0);
        chk_bit("midrst_c_drdy", bus.c_drdy, 1'b1);
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk_bit("post_rst_p_srdy", bus.p_srdy, 1'b0);
        tick();
        accept(word_c);
        for (int k = 0; k < 8; k++) begin
            expect_seg("word_c", word_c, k);
            tick();
        end
        @(negedge clk);
        chk_bit("word_c_done_p_srdy", bus.p_srdy, 1'b0);
        tick();

        // Single-segment instance: one word per cycle, p_ef always high.
        bus8.p_drdy = 1'b1;
        bus8.c_srdy = 1'b1;
        bus8.c_data = seq8[0];
        tick();
        for (int j = 1; j < 6; j++) begin
            bus8.c_data = seq8[j];
            @(negedge clk);
            chk_bit("w8_p_srdy", bus8.p_srdy, 1'b1);
            chk_byte("w8_p_data", bus8.p_data, seq8[j-1]);
            chk_bit("w8_p_ef", bus8.p_ef, 1'b1);
            chk_bit("w8_c_drdy", bus8.c_drdy, 1'b1);
            tick();
        end
        bus8.c_srdy = 1'b0;
        @(negedge clk);
        chk_byte("w8_last_p_data", bus8.p_data, seq8[5]);
        tick();
        @(negedge clk);
        chk_bit("w8_done_p_srdy", bus8.p_srdy, 1'b0);
        tick();

        // Random-gap stream of 100 words, rebuilt segment by segment and compared in order.
        tx  = 0;
        rx  = 0;
        cnt = 0;
        acc = '0;
        cyc = 0;
        while (rx < 100 && cyc < 5000) begin
            bus.c_srdy = (tx < 100) && ($urandom_range(0, 3) != 0);
            bus.c_data = 63'({$urandom(), $urandom()});
            bus.p_drdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.c_srdy && bus.c_drdy) begin
                sent.push_back(bus.c_data);
                tx++;
            end
            if (bus.p_srdy && bus.p_drdy) begin
                if (cnt < 8)
                    acc[8*cnt +: 8] = bus.p_data;
                cnt++;
                if (bus.p_ef) begin
                    chk_int("lb_seg_count", cnt, 8);
                    chk_bit("lb_word_available", sent.size() != 0, 1'b1);
                    if (sent.size() != 0) begin
                        front = sent.pop_front();
                        chk_word("lb_word", acc, {1'b0, front});
                    end
                    rx++;
                    cnt = 0;
                    acc = '0;
                end
            end
            tick();
            cyc++;
        end
        chk_int("lb_words_received", rx, 100);
        bus.c_srdy = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
